// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Writeback arbiter feeding the register-file write port.
//               ALU results have priority and are written one cycle later.
//               Load returns are buffered in a small FIFO and drained when
//               the ALU leaves the port free. Queued loads whose destination
//               is overwritten by a younger ALU result are squashed (WAW).
//               A load that stays blocked too long raises a one-cycle
//               alu_stall request.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int DATA_W       = 64,
    parameter int ADDR_W       = 5,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alu_valid,
    input  logic [ADDR_W-1:0]          alu_addr,
    input  logic [DATA_W-1:0]          alu_data,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [ADDR_W-1:0]          ld_addr,
    input  logic [DATA_W-1:0]          ld_data,
    output logic                       wb_en,
    output logic [ADDR_W-1:0]          wb_addr,
    output logic [DATA_W-1:0]          wb_data,
    output logic                       alu_stall,
    output logic [$clog2(DEPTH+1)-1:0] pend_cnt
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH+1);
    localparam int c_STV_W = $clog2(STARVE_LIMIT+1);

    // Load FIFO storage: live flag per entry, destination and data
    logic [DEPTH-1:0]   r_live;
    logic [ADDR_W-1:0]  r_addr [DEPTH];
    logic [DATA_W-1:0]  r_data [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_cnt;

    logic [c_STV_W-1:0] r_starve;
    logic               r_alu_stall;

    logic               r_wb_en;
    logic [ADDR_W-1:0]  r_wb_addr;
    logic [DATA_W-1:0]  r_wb_data;

    logic w_alu_win;
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_head_wr;
    logic w_blocked;

    // An ALU write to x0 is a no-op and does not claim the port
    assign w_alu_win = alu_valid && (alu_addr != '0);
    assign w_full    = (r_cnt == c_CNT_W'(DEPTH));
    assign w_empty   = (r_cnt == '0);
    // ld_ready depends only on registered occupancy: no same-cycle pass-through
    assign w_push    = ld_valid && !w_full;
    assign w_pop     = !w_alu_win && !w_empty;
    // Squashed or x0 heads are consumed without producing a write
    assign w_head_wr = r_live[r_rptr] && (r_addr[r_rptr] != '0);
    assign w_blocked = !w_empty && !w_pop;

    assign ld_ready  = !w_full;
    assign pend_cnt  = r_cnt;
    assign wb_en     = r_wb_en;
    assign wb_addr   = r_wb_addr;
    assign wb_data   = r_wb_data;
    assign alu_stall = r_alu_stall;

    // FIFO control: pointers, occupancy and live flags with WAW squash
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_live <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            // Squash every older entry targeting the register the ALU writes now
            for (int i = 0; i < DEPTH; i++) begin
                if (w_alu_win && (r_addr[i] == alu_addr)) begin
                    r_live[i] <= 1'b0;
                end
            end
            // A load accepted this cycle is younger than the ALU write: keep it live
            if (w_push) begin
                r_live[r_wptr] <= 1'b1;
                r_wptr         <= r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + c_CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - c_CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // FIFO payload storage; contents of empty slots are don't-care
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wptr] <= ld_addr;
            r_data[r_wptr] <= ld_data;
        end
    end

    // Starvation tracking: pulse alu_stall after STARVE_LIMIT blocked cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starve    <= '0;
            r_alu_stall <= 1'b0;
        end else begin
            r_alu_stall <= 1'b0;
            if (w_pop) begin
                r_starve <= '0;
            end else if (w_blocked) begin
                if (r_starve == c_STV_W'(STARVE_LIMIT - 1)) begin
                    r_starve    <= '0;
                    r_alu_stall <= 1'b1;
                end else begin
                    r_starve <= r_starve + c_STV_W'(1);
                end
            end
        end
    end

    // Registered write port: ALU first, then FIFO head; address/data hold when idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wb_en   <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else if (w_alu_win) begin
            r_wb_en   <= 1'b1;
            r_wb_addr <= alu_addr;
            r_wb_data <= alu_data;
        end else if (w_pop && w_head_wr) begin
            r_wb_en   <= 1'b1;
            r_wb_addr <= r_addr[r_rptr];
            r_wb_data <= r_data[r_rptr];
        end else begin
            r_wb_en   <= 1'b0;
        end
    end

endmodule
`default_nettype wire
